quarter_wave_sequencer: RTL and testbench

Address sequencer and sign stage for the DDS quarter-wave sine path. It walks the quarter-wave ROM forward or backward at a programmable step, starting from the quadrant start address supplied by the quadrant FSM. At each quadrant boundary it emits the one-cycle `trigger` that advances the FSM. It also applies the FSM polarity to the ROM magnitude, producing a signed sample stream.

---
 rtl/quarter_wave_sequencer.sv | 159 +++++++++++++++
 tb/tb_quarter_wave_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quarter_wave_sequencer.sv
// Quarter-wave ROM address sequencer for the DDS sine path: walks the ROM at a
// programmable step, pulses trigger at each quadrant boundary, and signs the ROM magnitude.
module quarter_wave_sequencer #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              src_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] step,
    input  logic              resync,
    input  logic              memdir,
    input  logic [ADDR_W-1:0] addr_rd,
    input  logic              data_pol,
    output logic              trigger,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W:0]   sample,
    output logic              sample_valid
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        TURN
    } state_t;

    localparam logic [ADDR_W:0] ADDR_MAX = {1'b0, {ADDR_W{1'b1}}};

    state_t            state;
    state_t            state_next;
    logic              turn_cnt;
    logic              turn_cnt_next;
    logic [ADDR_W-1:0] addr_next;
    logic              dir;
    logic              dir_next;
    logic              pol;
    logic              pol_next;
    logic              trigger_next;
    logic              issue;
    logic [ADDR_W:0]   fwd_sum;
    logic              boundary;

    logic              p1_valid;
    logic              p1_pol;
    logic [DATA_W:0]   sample_mag;
    logic [DATA_W:0]   sample_next;

    // The forward sum keeps one extra bit so the overflow past MAX is visible.
    always_comb begin
        fwd_sum  = {1'b0, rom_addr} + {1'b0, step};
        boundary = dir ? (step > rom_addr) : (fwd_sum > ADDR_MAX);
    end

    always_comb begin
        state_next    = state;
        turn_cnt_next = turn_cnt;
        addr_next     = rom_addr;
        dir_next      = dir;
        pol_next      = pol;
        trigger_next  = 1'b0;
        issue         = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = LOAD;
                end
            end

            LOAD: begin
                if (resync) begin
                    state_next    = TURN;
                    turn_cnt_next = 1'b0;
                end else begin
                    addr_next  = addr_rd;
                    dir_next   = memdir;
                    pol_next   = data_pol;
                    state_next = RUN;
                end
            end

            // resync discards the current address and pre-empts any boundary trigger.
            RUN: begin
                if (resync) begin
                    state_next    = TURN;
                    turn_cnt_next = 1'b0;
                end else if (enable) begin
                    issue = 1'b1;
                    if (boundary) begin
                        trigger_next  = 1'b1;
                        state_next    = TURN;
                        turn_cnt_next = 1'b0;
                    end else if (dir) begin
                        addr_next = rom_addr - step;
                    end else begin
                        addr_next = fwd_sum[ADDR_W-1:0];
                    end
                end
            end

            TURN: begin
                if (resync) begin
                    turn_cnt_next = 1'b0;
                end else if (turn_cnt) begin
                    state_next = LOAD;
                end else begin
                    turn_cnt_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            state    <= IDLE;
            turn_cnt <= 1'b0;
            rom_addr <= '0;
            dir      <= 1'b0;
            pol      <= 1'b0;
            trigger  <= 1'b0;
        end else begin
            state    <= state_next;
            turn_cnt <= turn_cnt_next;
            rom_addr <= addr_next;
            dir      <= dir_next;
            pol      <= pol_next;
            trigger  <= trigger_next;
        end
    end

    // Two's-complement negation of {0,mag} maps a zero magnitude to plain zero.
    always_comb begin
        sample_mag  = {1'b0, rom_data};
        sample_next = p1_pol ? -sample_mag : sample_mag;
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            p1_valid     <= 1'b0;
            p1_pol       <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            p1_valid     <= issue;
            p1_pol       <= pol;
            sample_valid <= p1_valid;
            if (p1_valid) begin
                sample <= sample_next;
            end
        end
    end

endmodule

// File: tb/tb_quarter_wave_sequencer.sv
// Bench for quarter_wave_sequencer: directed quadrant scenarios plus random traffic,
// checked every cycle against a cycle-numbered behavioural model and a stand-in quadrant FSM.
module tb_quarter_wave_sequencer;

    localparam int MAX_ADDR  = 127;
    localparam int OBS_DEPTH = 8192;

    logic       src_clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [6:0] step;
    logic       resync;
    logic       memdir;
    logic [6:0] addr_rd;
    logic       data_pol;
    logic       trigger;
    logic [6:0] rom_addr;
    logic [7:0] rom_data;
    logic [8:0] sample;
    logic       sample_valid;

    logic [7:0] rom_table [0:127];
    int         quad;

    always #5 src_clk = ~src_clk;

    // Stand-in quadrant FSM: S0 fwd/pos, S1 bwd/pos, S2 fwd/neg, S3 bwd/neg.
    assign memdir   = quad[0];
    assign data_pol = quad[1];
    assign addr_rd  = quad[0] ? 7'd127 : 7'd0;

    always @(posedge src_clk) rom_data <= rom_table[rom_addr];

    quarter_wave_sequencer #(.ADDR_W(7), .DATA_W(8)) dut (
        .src_clk      (src_clk),
        .rst          (rst),
        .enable       (enable),
        .step         (step),
        .resync       (resync),
        .memdir       (memdir),
        .addr_rd      (addr_rd),
        .data_pol     (data_pol),
        .trigger      (trigger),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    typedef struct {
        int due;
        int value;
    } pend_t;

    int    errors;
    int    checks;
    int    cyc;
    bit    m_started;
    bit    m_running;
    int    m_load_cycle;
    int    m_a;
    bit    m_dir;
    bit    m_pol;
    int    exp_addr;
    bit    exp_trig;
    bit    exp_reset_sample;
    pend_t pend_q[$];
    int    issue_addr[$];
    int    issue_cyc[$];
    int    obs_addr   [OBS_DEPTH];
    bit    obs_trig   [OBS_DEPTH];
    bit    obs_valid  [OBS_DEPTH];
    int    obs_sample [OBS_DEPTH];

    task automatic expectEq(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int signedOf(input logic [7:0] mag, input bit neg);
        int v;
        v = neg ? -int'(mag) : int'(mag);
        return v & 32'h1FF;
    endfunction

    function automatic int qAt(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int countTrig(input int first, input int last);
        int n;
        n = 0;
        for (int c = first; c <= last; c++) begin
            if (c < OBS_DEPTH && obs_trig[c]) n++;
        end
        return n;
    endfunction

    // Reference: from the inputs of cycle cyc, predict the outputs of cycle cyc+1.
    task automatic modelStep();
        int nxt;
        exp_trig         = 1'b0;
        exp_reset_sample = 1'b0;
        if (rst) begin
            m_started        = 1'b0;
            m_running        = 1'b0;
            m_load_cycle     = -1;
            m_a              = 0;
            m_dir            = 1'b0;
            m_pol            = 1'b0;
            exp_reset_sample = 1'b1;
            pend_q.delete();
        end else if (!m_started) begin
            if (enable) begin
                m_started    = 1'b1;
                m_load_cycle = cyc + 1;
            end
        end else if (resync) begin
            m_running    = 1'b0;
            m_load_cycle = cyc + 3;
        end else if (cyc == m_load_cycle) begin
            m_a          = int'(addr_rd);
            m_dir        = memdir;
            m_pol        = data_pol;
            m_running    = 1'b1;
            m_load_cycle = -1;
        end else if (m_running && enable) begin
            issue_addr.push_back(int'(rom_addr));
            issue_cyc.push_back(cyc);
            pend_q.push_back('{cyc + 2, signedOf(rom_table[m_a], m_pol)});
            nxt = m_dir ? m_a - int'(step) : m_a + int'(step);
            if (nxt < 0 || nxt > MAX_ADDR) begin
                exp_trig     = 1'b1;
                m_running    = 1'b0;
                m_load_cycle = cyc + 3;
            end else begin
                m_a = nxt;
            end
        end
        exp_addr = m_a;
    endtask

    task automatic checkOutput();
        bit want_valid;
        int want_sample;
        want_valid  = 1'b0;
        want_sample = 0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            want_valid  = 1'b1;
            want_sample = pend_q[0].value;
            pend_q.delete(0);
        end
        expectEq("rom_addr", int'(rom_addr), exp_addr);
        expectEq("trigger", int'(trigger), int'(exp_trig));
        expectEq("sample_valid", int'(sample_valid), int'(want_valid));
        if (want_valid) expectEq("sample", int'(sample), want_sample);
        if (exp_reset_sample) expectEq("sample_after_reset", int'(sample), 0);
        if (cyc < OBS_DEPTH) begin
            obs_addr[cyc]   = int'(rom_addr);
            obs_trig[cyc]   = trigger;
            obs_valid[cyc]  = sample_valid;
            obs_sample[cyc] = int'(sample);
        end
        if (trigger) quad = (quad + 1) % 4;
    endtask

    task automatic tick();
        modelStep();
        @(negedge src_clk);
        cyc++;
        checkOutput();
    endtask

    task automatic applyStimulus(input bit r, input bit en, input bit rs, input int st);
        rst    = r;
        enable = en;
        resync = rs;
        step   = 7'(st);
        tick();
    endtask

    task automatic resetCycle();
        quad = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        issue_addr.delete();
        issue_cyc.delete();
    endtask

    int p2_addr [12] = '{0, 50, 100, 127, 77, 27, 0, 50, 100, 127, 77, 27};
    int p2_cyc  [12] = '{2, 3, 4, 8, 9, 10, 14, 15, 16, 20, 21, 22};

    initial begin
        int t0;
        int cur_step;
        bit r_v;
        bit rs_v;
        bit en_v;

        for (int i = 0; i < 128; i++) rom_table[i] = 8'($urandom_range(0, 255));
        rom_table[0]   = 8'hFF;
        rom_table[50]  = 8'h80;
        rom_table[127] = 8'h00;

        rst = 1'b1; enable = 1'b0; resync = 1'b0; step = '0; quad = 0;
        errors = 0; checks = 0; cyc = 0;
        m_started = 1'b0; m_running = 1'b0; m_load_cycle = -1;
        m_a = 0; m_dir = 1'b0; m_pol = 1'b0;
        exp_addr = 0; exp_trig = 1'b0; exp_reset_sample = 1'b1;

        repeat (3) @(negedge src_clk);
        checkOutput();
        expectEq("reset_rom_addr", int'(rom_addr), 0);
        expectEq("reset_trigger", int'(trigger), 0);
        expectEq("reset_sample_valid", int'(sample_valid), 0);

        // Step 1 through S0 and into S1.
        resetCycle();
        t0 = cyc;
        repeat (140) applyStimulus(1'b0, 1'b1, 1'b0, 1);
        expectEq("p1_issue_count", issue_addr.size(), 135);
        for (int i = 0; i < 128; i++) begin
            expectEq("p1_issue_addr", qAt(issue_addr, i), i);
            expectEq("p1_issue_cycle", qAt(issue_cyc, i) - t0, 2 + i);
        end
        expectEq("p1_trigger_count", countTrig(t0, cyc), 1);
        expectEq("p1_trigger_cycle", int'(obs_trig[t0 + 130]), 1);
        expectEq("p1_s1_first_addr", qAt(issue_addr, 128), 127);
        expectEq("p1_s1_first_cycle", qAt(issue_cyc, 128) - t0, 133);
        expectEq("p1_s1_second_addr", qAt(issue_addr, 129), 126);

        // Step 50 across all four quadrants, with polarity samples.
        resetCycle();
        t0 = cyc;
        repeat (25) applyStimulus(1'b0, 1'b1, 1'b0, 50);
        expectEq("p2_issue_count", issue_addr.size(), 12);
        for (int i = 0; i < 12; i++) begin
            expectEq("p2_issue_addr", qAt(issue_addr, i), p2_addr[i]);
            expectEq("p2_issue_cycle", qAt(issue_cyc, i) - t0, p2_cyc[i]);
        end
        expectEq("p2_trigger_count", countTrig(t0, cyc), 4);
        expectEq("p2_pos_80_valid", int'(obs_valid[t0 + 5]), 1);
        expectEq("p2_pos_80_sample", obs_sample[t0 + 5], 9'h080);
        expectEq("p2_neg_ff_valid", int'(obs_valid[t0 + 16]), 1);
        expectEq("p2_neg_ff_sample", obs_sample[t0 + 16], 9'h101);
        expectEq("p2_neg_zero_valid", int'(obs_valid[t0 + 22]), 1);
        expectEq("p2_neg_zero_sample", obs_sample[t0 + 22], 9'h000);

        // Enable pattern 1,0,0,1 then step 0 for 1000 cycles.
        resetCycle();
        t0 = cyc;
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 3);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 3);
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 3);
        repeat (1000) applyStimulus(1'b0, 1'b1, 1'b0, 0);
        expectEq("p3_hold_addr_a", obs_addr[t0 + 6], 12);
        expectEq("p3_hold_addr_b", obs_addr[t0 + 7], 12);
        expectEq("p3_hold_addr_c", obs_addr[t0 + 8], 12);
        expectEq("p3_resume_addr", obs_addr[t0 + 9], 15);
        expectEq("p3_valid_before_gap", int'(obs_valid[t0 + 7]), 1);
        expectEq("p3_gap_valid_a", int'(obs_valid[t0 + 8]), 0);
        expectEq("p3_gap_valid_b", int'(obs_valid[t0 + 9]), 0);
        expectEq("p3_valid_after_gap", int'(obs_valid[t0 + 10]), 1);
        expectEq("p3_step0_addr", obs_addr[t0 + 1013], 27);
        expectEq("p3_step0_valid", int'(obs_valid[t0 + 1013]), 1);
        expectEq("p3_step0_triggers", countTrig(t0, cyc), 0);

        // resync at address 60 into S2, then resync coincident with a boundary into S3.
        resetCycle();
        t0 = cyc;
        repeat (62) applyStimulus(1'b0, 1'b1, 1'b0, 1);
        quad = 2;
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        repeat (130) applyStimulus(1'b0, 1'b1, 1'b0, 1);
        quad = 3;
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        repeat (7) applyStimulus(1'b0, 1'b1, 1'b0, 1);
        expectEq("p4_resync_at_addr", obs_addr[t0 + 62], 60);
        expectEq("p4_triggers", countTrig(t0, cyc), 0);
        expectEq("p4_s2_first_addr", obs_addr[t0 + 66], 0);
        expectEq("p4_s2_first_valid", int'(obs_valid[t0 + 68]), 1);
        expectEq("p4_s2_first_sample", obs_sample[t0 + 68], 9'h101);
        expectEq("p4_boundary_addr", obs_addr[t0 + 193], 127);
        expectEq("p4_s3_first_addr", obs_addr[t0 + 197], 127);

        // Reset while in TURN, then re-enable.
        resetCycle();
        t0 = cyc;
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 50);
        quad = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 50);
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 50);
        expectEq("p5_trigger_before_reset", int'(obs_trig[t0 + 5]), 1);
        expectEq("p5_reset_addr", obs_addr[t0 + 6], 0);
        expectEq("p5_reset_trigger", int'(obs_trig[t0 + 6]), 0);
        expectEq("p5_reset_valid", int'(obs_valid[t0 + 6]), 0);
        expectEq("p5_reset_sample", obs_sample[t0 + 6], 0);
        expectEq("p5_restart_addr_a", obs_addr[t0 + 8], 0);
        expectEq("p5_restart_addr_b", obs_addr[t0 + 9], 50);

        // Random traffic against the model.
        resetCycle();
        cur_step = $urandom_range(1, 40);
        for (int i = 0; i < 3000; i++) begin
            r_v  = 1'b0;
            rs_v = 1'b0;
            if ($urandom_range(0, 199) == 0)
                cur_step = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 127);
            en_v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) begin
                rs_v = 1'b1;
                quad = $urandom_range(0, 3);
            end
            if ($urandom_range(0, 999) == 0) begin
                r_v  = 1'b1;
                quad = 0;
            end
            applyStimulus(r_v, en_v, rs_v, cur_step);
        end
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, cur_step);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
